// File: rtl/cond_unit_if.sv
// ALU flag / decoder bundle between the datapath and cond_unit.
// master drives decoder and ALU fields; slave is the condition unit.
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [2:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             instr_valid;
  logic             stall;
  logic             cnt_clr;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic             carry_in;
  logic [CNT_W-1:0] CondFailCount;

  modport master (
    output Cond, ALUFlags, FlagW,
    output PCS, RegW, MemW, NoWrite,
    output instr_valid, stall, cnt_clr,
    input  CondEx, PCSrc, RegWrite, MemWrite,
    input  Flags, carry_in, CondFailCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW,
    input  PCS, RegW, MemW, NoWrite,
    input  instr_valid, stall, cnt_clr,
    output CondEx, PCSrc, RegWrite, MemWrite,
    output Flags, carry_in, CondFailCount
  );
endinterface

// File: rtl/cond_unit.sv
// Condition unit: NZCV register, condition check, write-enable gating
// and a saturating count of condition-failed instructions.
module cond_unit #(
  parameter int         CNT_W       = 16,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic      clk,
  input  logic      reset_n,
  cond_unit_if.slave bus
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cond_ex;
  logic             retire;
  logic             n, z, c, v;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  assign retire = bus.instr_valid & ~bus.stall & reset_n;

  // Condition check uses only the registered flags
  always_comb begin
    cond_ex = 1'b0;
    unique case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b0;
    endcase
  end

  // Next flags: per-field write enables, only on a passing retire
  always_comb begin
    flags_d = flags_q;
    if (retire && cond_ex) begin
      if (bus.FlagW[2]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[1]) flags_d[1]   = bus.ALUFlags[1];
      if (bus.FlagW[0]) flags_d[0]   = bus.ALUFlags[0];
    end
  end

  // Next count: clear wins, else saturating increment on failed retire
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (retire && !cond_ex && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= RESET_FLAGS;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.CondEx        = cond_ex;
  assign bus.PCSrc         = bus.PCS & cond_ex & retire;
  assign bus.RegWrite      = bus.RegW & ~bus.NoWrite & cond_ex & retire;
  assign bus.MemWrite      = bus.MemW & cond_ex & retire;
  assign bus.Flags         = flags_q;
  assign bus.carry_in      = flags_q[1];
  assign bus.CondFailCount = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit with a 2-bit fail counter.
// Inputs change 1ns after the rising edge; checks follow a settle delay.
module tb_cond_unit;

  localparam int CNT_W = 2;

  localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010, CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100, PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110, VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000, LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010, LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100, LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110, NV = 4'b1111;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  cond_unit_if #(.CNT_W(CNT_W)) bus ();

  cond_unit #(
    .CNT_W      (CNT_W),
    .RESET_FLAGS(4'b0000)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cond(input logic [3:0] c, input logic exp,
                      input string tag);
    bus.Cond = c;
    #1;
    chk(tag, 32'(bus.CondEx), 32'(exp));
  endtask

  task automatic load_flags(input logic [3:0] f);
    bus.Cond        = AL;
    bus.ALUFlags    = f;
    bus.FlagW       = 3'b111;
    bus.instr_valid = 1'b1;
    bus.stall       = 1'b0;
    tick();
    bus.FlagW = 3'b000;
    #1;
    chk("load_flags", 32'(bus.Flags), 32'(f));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.Cond        = AL;
    bus.ALUFlags    = 4'b0000;
    bus.FlagW       = 3'b000;
    bus.PCS         = 1'b0;
    bus.RegW        = 1'b1;
    bus.MemW        = 1'b0;
    bus.NoWrite     = 1'b0;
    bus.instr_valid = 1'b1;
    bus.stall       = 1'b0;
    bus.cnt_clr     = 1'b0;
    #2;
    chk("rst_flags", 32'(bus.Flags), 32'h0);
    chk("rst_condex", 32'(bus.CondEx), 32'h1);
    chk("rst_regwrite", 32'(bus.RegWrite), 32'h0);
    chk("rst_count", 32'(bus.CondFailCount), 32'h0);
    tick();
    chk("rst_hold_flags", 32'(bus.Flags), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("al_regwrite", 32'(bus.RegWrite), 32'h1);
    chk("al_flags", 32'(bus.Flags), 32'h0);

    // Flag write with latency of one cycle
    bus.ALUFlags = 4'b0100;
    bus.FlagW    = 3'b111;
    #1;
    chk("own_result_unseen", 32'(bus.Flags), 32'h0);
    cond(EQ, 1'b0, "eq_before_edge");
    bus.Cond = AL;
    tick();
    bus.FlagW = 3'b000;
    chk("z_written", 32'(bus.Flags), 32'h4);
    cond(EQ, 1'b1, "eq_z1");
    bus.PCS  = 1'b1;
    bus.MemW = 1'b1;
    cond(NE, 1'b0, "ne_z1");
    chk("ne_regwrite", 32'(bus.RegWrite), 32'h0);
    chk("ne_memwrite", 32'(bus.MemWrite), 32'h0);
    chk("ne_pcsrc", 32'(bus.PCSrc), 32'h0);
    bus.PCS  = 1'b0;
    bus.MemW = 1'b0;

    // Signed comparisons
    load_flags(4'b1001);
    cond(GE, 1'b1, "ge_1001");
    cond(LT, 1'b0, "lt_1001");
    cond(GT, 1'b1, "gt_1001");
    load_flags(4'b1000);
    cond(LE, 1'b1, "le_1000");
    cond(GT, 1'b0, "gt_1000");
    cond(MI, 1'b1, "mi_1000");
    cond(PL, 1'b0, "pl_1000");
    load_flags(4'b0001);
    cond(VS, 1'b1, "vs_0001");
    cond(VC, 1'b0, "vc_0001");
    cond(GE, 1'b0, "ge_0001");
    cond(LT, 1'b1, "lt_0001");
    cond(GT, 1'b0, "gt_0001");
    cond(LE, 1'b1, "le_0001");
    load_flags(4'b0010);
    cond(HI, 1'b1, "hi_0010");
    cond(LS, 1'b0, "ls_0010");
    cond(CS, 1'b1, "cs_0010");
    cond(CC, 1'b0, "cc_0010");
    chk("carry_in_0010", 32'(bus.carry_in), 32'h1);
    load_flags(4'b0110);
    cond(HI, 1'b0, "hi_0110");
    cond(LS, 1'b1, "ls_0110");
    cond(GT, 1'b0, "gt_0110");
    cond(NE, 1'b0, "ne_0110");

    // NV never passes
    for (int i = 0; i < 16; i++) begin
      load_flags(4'(i));
      cond(NV, 1'b0, "nv_all");
    end

    // Logical op: N,Z,C written, V preserved
    load_flags(4'b0011);
    bus.Cond     = AL;
    bus.FlagW    = 3'b110;
    bus.ALUFlags = 4'b1000;
    tick();
    chk("logic_flags", 32'(bus.Flags), 32'h9);
    chk("logic_carry_in", 32'(bus.carry_in), 32'h0);
    load_flags(4'b0011);
    bus.Cond     = EQ;
    bus.FlagW    = 3'b110;
    bus.ALUFlags = 4'b1000;
    tick();
    chk("failed_no_write", 32'(bus.Flags), 32'h3);
    chk("failed_counted", 32'(bus.CondFailCount), 32'h1);

    // Saturating counter
    bus.cnt_clr = 1'b1;
    bus.instr_valid = 1'b0;
    tick();
    chk("cnt_cleared", 32'(bus.CondFailCount), 32'h0);
    bus.cnt_clr     = 1'b0;
    bus.instr_valid = 1'b1;
    bus.Cond        = NV;
    bus.FlagW       = 3'b111;
    bus.ALUFlags    = 4'b1111;
    tick();
    chk("cnt_1", 32'(bus.CondFailCount), 32'h1);
    tick();
    chk("cnt_2", 32'(bus.CondFailCount), 32'h2);
    tick();
    chk("cnt_3", 32'(bus.CondFailCount), 32'h3);
    tick();
    chk("cnt_sat", 32'(bus.CondFailCount), 32'h3);
    chk("nv_flags_hold", 32'(bus.Flags), 32'h3);
    bus.cnt_clr = 1'b1;
    tick();
    chk("clr_priority", 32'(bus.CondFailCount), 32'h0);
    bus.cnt_clr = 1'b0;

    // Stall: hold state, no enables
    bus.stall = 1'b1;
    bus.PCS   = 1'b1;
    bus.MemW  = 1'b1;
    tick();
    chk("stall_cnt", 32'(bus.CondFailCount), 32'h0);
    chk("stall_flags", 32'(bus.Flags), 32'h3);
    cond(AL, 1'b1, "stall_condex");
    tick();
    chk("stall_al_flags", 32'(bus.Flags), 32'h3);
    chk("stall_regwrite", 32'(bus.RegWrite), 32'h0);
    chk("stall_memwrite", 32'(bus.MemWrite), 32'h0);
    chk("stall_pcsrc", 32'(bus.PCSrc), 32'h0);
    bus.stall = 1'b0;
    bus.PCS   = 1'b0;
    bus.MemW  = 1'b0;

    // CMP: flags written, no register write
    bus.Cond     = AL;
    bus.NoWrite  = 1'b1;
    bus.FlagW    = 3'b111;
    bus.ALUFlags = 4'b0110;
    #1;
    chk("cmp_regwrite", 32'(bus.RegWrite), 32'h0);
    tick();
    chk("cmp_flags", 32'(bus.Flags), 32'h6);
    bus.NoWrite = 1'b0;
    bus.FlagW   = 3'b000;
    bus.MemW    = 1'b1;
    bus.PCS     = 1'b1;
    cond(CS, 1'b1, "cs_c1");
    chk("cs_memwrite", 32'(bus.MemWrite), 32'h1);
    chk("cs_pcsrc", 32'(bus.PCSrc), 32'h1);
    chk("cs_regwrite", 32'(bus.RegWrite), 32'h1);
    bus.instr_valid = 1'b0;
    #1;
    chk("invalid_memwrite", 32'(bus.MemWrite), 32'h0);
    bus.instr_valid = 1'b1;

    // Reset mid-operation
    bus.Cond     = AL;
    bus.FlagW    = 3'b111;
    bus.ALUFlags = 4'b1111;
    reset_n      = 1'b0;
    #1;
    chk("midrst_flags", 32'(bus.Flags), 32'h0);
    chk("midrst_memwrite", 32'(bus.MemWrite), 32'h0);
    tick();
    chk("midrst_edge_ignored", 32'(bus.Flags), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("after_rst_write", 32'(bus.Flags), 32'hf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
